// File: rtl/dac7611_rx.sv
// Serial receiver for a DAC7611-style 3-wire link (CLK/SDI/LD plus CLR),
// oversampled by clk_X4; latches complete frames into dac_code.
module dac7611_rx #(
   parameter int unsigned              DATA_BITS = 12,
   parameter logic [DATA_BITS-1:0]     CLR_VALUE = 12'h000
) (
   input  logic                 clk_X4,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 CLK_3,
   input  logic                 SDI_4,
   input  logic                 LD_5,
   input  logic                 CLR_6,
   output logic [DATA_BITS-1:0] dac_code,
   output logic                 code_update,
   output logic                 frame_err,
   output logic                 clr_active,
   output logic [15:0]          frame_cnt
);

   localparam logic [3:0] FULL_CNT = 4'(DATA_BITS);

   logic clk_s1, clk_s2, sdi_s1, sdi_s2, ld_s1, ld_s2, clr_s1, clr_s2;
   logic clk_prev, ld_prev;
   logic clk_rise, ld_fall;

   logic [DATA_BITS-1:0] shreg, shreg_nxt, code_nxt;
   logic [3:0]           bit_cnt, cnt_nxt;
   logic [15:0]          fcnt_nxt;
   logic                 upd_nxt, err_nxt;

   // Idle levels of the serial lines are the synchronizer reset values, so
   // release from reset never fakes an edge.
   always_ff @(posedge clk_X4 or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         sdi_s1   <= 1'b0;
         sdi_s2   <= 1'b0;
         ld_s1    <= 1'b1;
         ld_s2    <= 1'b1;
         clr_s1   <= 1'b1;
         clr_s2   <= 1'b1;
         clk_prev <= 1'b1;
         ld_prev  <= 1'b1;
      end else begin
         clk_s1   <= CLK_3;
         clk_s2   <= clk_s1;
         sdi_s1   <= SDI_4;
         sdi_s2   <= sdi_s1;
         ld_s1    <= LD_5;
         ld_s2    <= ld_s1;
         clr_s1   <= CLR_6;
         clr_s2   <= clr_s1;
         clk_prev <= clk_s2;
         ld_prev  <= ld_s2;
      end
   end

   assign clk_rise   = clk_s2 & ~clk_prev;
   assign ld_fall    = ~ld_s2 & ld_prev;
   assign clr_active = ~clr_s2;

   // Priority: clear, then disable, then load strobe, then shift.
   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = bit_cnt;
      code_nxt  = dac_code;
      fcnt_nxt  = frame_cnt;
      upd_nxt   = 1'b0;
      err_nxt   = 1'b0;
      if (!clr_s2) begin
         code_nxt  = CLR_VALUE;
         shreg_nxt = '0;
         cnt_nxt   = '0;
      end else if (!enable) begin
         shreg_nxt = '0;
         cnt_nxt   = '0;
      end else if (ld_fall) begin
         shreg_nxt = '0;
         cnt_nxt   = '0;
         if (bit_cnt == FULL_CNT) begin
            code_nxt = shreg;
            fcnt_nxt = frame_cnt + 16'd1;
            upd_nxt  = 1'b1;
         end else begin
            err_nxt  = 1'b1;
         end
      end else if (clk_rise && ld_s2) begin
         shreg_nxt = {shreg[DATA_BITS-2:0], sdi_s2};
         if (bit_cnt != 4'hF) cnt_nxt = bit_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk_X4 or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         dac_code    <= CLR_VALUE;
         frame_cnt   <= '0;
         code_update <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         shreg       <= shreg_nxt;
         bit_cnt     <= cnt_nxt;
         dac_code    <= code_nxt;
         frame_cnt   <= fcnt_nxt;
         code_update <= upd_nxt;
         frame_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_dac7611_rx.sv
// Scoreboard bench for dac7611_rx: frames are modelled as bit lists and
// expected load/error events are queued for an independent monitor.
module tb_dac7611_rx;

   logic        clk_X4 = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b1;
   logic        CLK_3  = 1'b1;
   logic        SDI_4  = 1'b0;
   logic        LD_5   = 1'b1;
   logic        CLR_6  = 1'b1;
   logic [11:0] dac_code;
   logic        code_update;
   logic        frame_err;
   logic        clr_active;
   logic [15:0] frame_cnt;

   dac7611_rx #(.DATA_BITS(12), .CLR_VALUE(12'h000)) dut (
      .clk_X4(clk_X4), .rst_n(rst_n), .enable(enable),
      .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5), .CLR_6(CLR_6),
      .dac_code(dac_code), .code_update(code_update), .frame_err(frame_err),
      .clr_active(clr_active), .frame_cnt(frame_cnt)
   );

   always #5 clk_X4 = ~clk_X4;

   int cyc = 0;
   always @(posedge clk_X4) cyc <= cyc + 1;

   typedef struct {
      bit          upd;
      logic [11:0] code;
      logic [15:0] cnt;
      int          at;
   } exp_t;
   exp_t sb[$];

   int          checks = 0;
   int          passes = 0;
   logic [11:0] model_code = 12'h000;
   logic [15:0] model_cnt  = 16'h0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk_X4);
      #1;
   endtask

   task automatic shift_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         CLK_3 = 1'b0;
         SDI_4 = v[i];
         tick(); tick();
         CLK_3 = 1'b1;
         tick(); tick();
      end
   endtask

   // Sends n bits of v MSB first, then strobes LD; the model decides the outcome.
   task automatic send_frame(input logic [31:0] v, input int n);
      exp_t e;
      shift_bits(v, n);
      if (enable) begin
         if (n == 12) begin
            model_code = v[11:0];
            model_cnt  = model_cnt + 16'd1;
         end
         e.upd  = (n == 12);
         e.code = model_code;
         e.cnt  = model_cnt;
         e.at   = cyc;
         sb.push_back(e);
      end
      LD_5 = 1'b0;
      tick(); tick();
      LD_5 = 1'b1;
      repeat (4) tick();
   endtask

   always @(negedge clk_X4) begin
      if (rst_n && (code_update || frame_err)) begin
         chk("pulse_exclusive", 32'(code_update & frame_err), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'({code_update, frame_err}), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("code_update", 32'(code_update), 32'(e.upd));
            chk("frame_err", 32'(frame_err), 32'(!e.upd));
            chk("dac_code", 32'(dac_code), 32'(e.code));
            chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            chk("pulse_latency", 32'(cyc), 32'(e.at + 3));
         end
      end
   end

   initial begin
      int n;
      logic [31:0] v;

      repeat (3) tick();
      chk("rst_dac_code", 32'(dac_code), 32'h000);
      chk("rst_code_update", 32'(code_update), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_clr_active", 32'(clr_active), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      send_frame(32'hAAA, 12);
      chk("aaa_code", 32'(dac_code), 32'hAAA);
      chk("aaa_cnt", 32'(frame_cnt), 32'd1);

      send_frame(32'hC3, 8);
      chk("short_hold", 32'(dac_code), 32'hAAA);
      send_frame(32'h5A5, 12);
      chk("5a5_code", 32'(dac_code), 32'h5A5);

      send_frame(32'h2ABC, 14);
      send_frame(32'h0ABC_DEF1, 28);   // a wrapping counter would read 12 here
      chk("long_hold", 32'(dac_code), 32'h5A5);
      chk("long_cnt", 32'(frame_cnt), 32'(model_cnt));

      send_frame(32'hFFF, 12);
      CLR_6 = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk_X4);
         #1;
         if (i == 2) CLR_6 = 1'b1;
         @(negedge clk_X4);
         chk("clr_active", 32'(clr_active), 32'((i == 2) || (i == 3)));
      end
      tick();
      model_code = 12'h000;
      chk("clr_code", 32'(dac_code), 32'h000);

      send_frame(32'h777, 12);
      shift_bits(32'h9E1, 12);
      CLR_6 = 1'b0;
      LD_5  = 1'b0;
      tick(); tick();
      CLR_6 = 1'b1;
      LD_5  = 1'b1;
      repeat (6) tick();
      model_code = 12'h000;
      chk("clr_ld_code", 32'(dac_code), 32'h000);
      chk("clr_ld_cnt", 32'(frame_cnt), 32'(model_cnt));

      shift_bits(32'h2D, 6);
      rst_n = 1'b0;
      #1;
      chk("midrst_code", 32'(dac_code), 32'h000);
      chk("midrst_cnt", 32'(frame_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      model_code = 12'h000;
      model_cnt  = 16'h0000;
      repeat (3) tick();
      send_frame(32'h123, 12);
      chk("postrst_code", 32'(dac_code), 32'h123);
      chk("postrst_cnt", 32'(frame_cnt), 32'd1);

      enable = 1'b0;
      send_frame(32'h3C3, 12);
      chk("dis_code", 32'(dac_code), 32'h123);
      chk("dis_cnt", 32'(frame_cnt), 32'd1);
      enable = 1'b1;
      repeat (2) tick();

      for (int k = 0; k < 24; k++) begin
         n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 12;
         v = $urandom;
         enable = ($urandom_range(0, 7) != 0);
         send_frame(v, n);
         chk("rand_code", 32'(dac_code), 32'(model_code));
      end
      enable = 1'b1;
      repeat (2) tick();

      force dut.frame_cnt = 16'hFFFF;
      tick();
      release dut.frame_cnt;
      model_cnt = 16'hFFFF;
      send_frame(32'h456, 12);
      chk("wrap_cnt", 32'(frame_cnt), 32'd0);

      for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
